alu_seq_ctrl: RTL and testbench

- Multi-byte operation sequencer for the shared 8-bit ALU (ops ADD/SUB/AND/OR, carry-out valid for ADD only, no carry-in).
- Takes one NBYTES-wide request over a valid/ready handshake and drives the ALU one byte per cycle, LSB first. It adds a second ADD pass when carry-in is needed.
- Returns the full-width result and carry over a valid/ready response handshake.
- Sits between the instruction/control logic and the ALU; the ALU is external and purely combinational.

---
 rtl/alu_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Multi-byte sequencer that drives a shared combinational 8-bit ALU one byte per pass, LSB first.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_ovf outputs.
module alu_seq_ctrl #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [1:0]   alu_cond,
  input  logic [7:0]   alu_out,
  input  logic         alu_carry
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic         rsp_zero,
  output logic         rsp_ovf
`endif
);

  localparam int         IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b00;

  typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;        // SUB stores ~B so every arithmetic pass is an ADD
  logic [W-1:0]  res_q;
  logic          c_q;
  logic          c1_q;
  logic [IW-1:0] i_q;

  logic          advance;
  logic          last;
  logic          c_next;
  logic [W-1:0]  res_next;

  assign req_ready = (state == IDLE) && !rst;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    advance  = 1'b0;
    c_next   = c_q;
    res_next = res_q;
    res_next[8*int'(i_q) +: 8] = alu_out;
    last     = (i_q == IW'(NBYTES - 1));
    case (state)
      P1: begin
        if (op_q[1]) begin
          advance = 1'b1;
          c_next  = 1'b0;
        end else if (!c_q) begin
          advance = 1'b1;
          c_next  = alu_carry;
        end
      end
      P2: begin
        advance = 1'b1;
        c_next  = c1_q | alu_carry;
      end
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      c_q        <= 1'b0;
      c1_q       <= 1'b0;
      i_q        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cond   <= 2'b00;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q     <= req_op;
            a_q      <= req_a;
            b_q      <= (req_op == OP_SUB) ? ~req_b : req_b;
            c_q      <= (req_op == OP_SUB);
            i_q      <= '0;
            alu_a    <= req_a[7:0];
            alu_b    <= (req_op == OP_SUB) ? ~req_b[7:0] : req_b[7:0];
            alu_cond <= req_op[1] ? req_op : 2'b00;
            state    <= P1;
          end
        end
        P1, P2: begin
          if (advance) begin
            res_q <= res_next;
            c_q   <= c_next;
            if (last) begin
              state      <= DONE;
              rsp_valid  <= 1'b1;
              rsp_result <= res_next;
              rsp_carry  <= c_next;
`ifdef ALU_SEQ_FLAGS_EN
              rsp_zero   <= (res_next == '0);
              rsp_ovf    <= !op_q[1] && (a_q[W-1] == b_q[W-1]) && (res_next[W-1] != a_q[W-1]);
`endif
              alu_a      <= '0;
              alu_b      <= '0;
              alu_cond   <= 2'b00;
            end else begin
              i_q      <= i_q + IW'(1);
              alu_a    <= a_q[8*(int'(i_q) + 1) +: 8];
              alu_b    <= b_q[8*(int'(i_q) + 1) +: 8];
              alu_cond <= op_q[1] ? op_q : 2'b00;
              state    <= P1;
            end
          end else begin
            // Carry-in pending: add the incoming carry to the partial sum in a second pass.
            c1_q     <= alu_carry;
            alu_a    <= alu_out;
            alu_b    <= 8'h01;
            alu_cond <= 2'b00;
            state    <= P2;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (NBYTES=4) with a behavioural 8-bit ALU and a response scoreboard.
module tb_alu_seq_ctrl;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry;
    logic         zero;
    logic         ovf;
    int           lat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [1:0]   alu_cond;
  logic [7:0]   alu_out;
  logic         alu_carry;
`ifdef ALU_SEQ_FLAGS_EN
  logic         rsp_zero;
  logic         rsp_ovf;
`endif

  int   checks = 0;
  int   passes = 0;
  vec_t sb[$];

  alu_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cond(alu_cond),
    .alu_out(alu_out), .alu_carry(alu_carry)
`ifdef ALU_SEQ_FLAGS_EN
    , .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf)
`endif
  );

  always #5 clk = ~clk;

  // External ALU: carry is meaningful for ADD only.
  always_comb begin
    alu_carry = 1'b0;
    case (alu_cond)
      2'b00:   {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   alu_out = alu_a - alu_b;
      2'b10:   alu_out = alu_a & alu_b;
      default: alu_out = alu_a | alu_b;
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    checks++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Independent reference: plain wide arithmetic for value/flags, byte walk for pass count.
  function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    vec_t       v;
    logic [W:0] wide;
    logic [W-1:0] bp;
    logic [8:0] s9;
    logic [8:0] t9;
    logic       c;
    v.op = op; v.a = a; v.b = b; v.carry = 1'b0; v.lat = 0;
    bp = (op == 2'b01) ? ~b : b;
    case (op)
      2'b00: begin wide = {1'b0, a} + {1'b0, b}; v.res = wide[W-1:0]; v.carry = wide[W]; end
      2'b01: begin v.res = a - b; v.carry = (a >= b); end
      2'b10: v.res = a & b;
      default: v.res = a | b;
    endcase
    v.zero = (v.res == '0);
    v.ovf  = !op[1] && (a[W-1] == bp[W-1]) && (v.res[W-1] != a[W-1]);
    c = (op == 2'b01);
    for (int k = 0; k < W/8; k++) begin
      if (op[1]) v.lat++;
      else begin
        s9 = {1'b0, a[8*k +: 8]} + {1'b0, bp[8*k +: 8]};
        if (c) begin
          t9 = {1'b0, s9[7:0]} + 9'd1;
          c = s9[8] | t9[8];
          v.lat += 2;
        end else begin
          c = s9[8];
          v.lat++;
        end
      end
    end
    return v;
  endfunction

  // Called just after an active edge; returns just after the accepting edge.
  task automatic send(input vec_t v);
    int n = 0;
    req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1'b1;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!req_ready) timeout("req_ready");
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(v);
  endtask

  task automatic wait_rsp(input string tag);
    int   lat = 0;
    vec_t e;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin timeout({tag, "_rsp"}); return; end
    if (sb.size() == 0) begin timeout({tag, "_sb_empty"}); return; end
    e = sb.pop_front();
    check({tag, "_result"}, rsp_result, e.res);
    check({tag, "_carry"}, W'(rsp_carry), W'(e.carry));
    check({tag, "_latency"}, W'(lat), W'(e.lat));
`ifdef ALU_SEQ_FLAGS_EN
    check({tag, "_zero"}, W'(rsp_zero), W'(e.zero));
    check({tag, "_ovf"}, W'(rsp_ovf), W'(e.ovf));
`endif
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "_valid_low"}, W'(rsp_valid), W'(0));
    check({tag, "_ready_idle"}, W'(req_ready), W'(1));
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    logic saw_valid;
    vecs[0] = '{2'b00, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 5};
    vecs[1] = '{2'b01, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 5};
    vecs[2] = '{2'b01, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 8};
    vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 7};
    vecs[4] = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 7};
    vecs[5] = '{2'b10, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1'b0, 4};
    vecs[6] = '{2'b11, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0, 1'b0, 4};

    // Reset state
    #2;
    check("rst_req_ready", W'(req_ready), W'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rsp_valid", W'(rsp_valid), W'(0));
    check("rst_rsp_result", rsp_result, '0);
    check("rst_rsp_carry", W'(rsp_carry), W'(0));
    check("rst_alu_a", W'(alu_a), W'(0));
    check("rst_alu_b", W'(alu_b), W'(0));
    check("rst_alu_cond", W'(alu_cond), W'(0));
    check("rst_req_ready_idle", W'(req_ready), W'(1));

    // Table vectors
    for (int k = 0; k < 7; k++) begin
      send(vecs[k]);
      wait_rsp($sformatf("vec%0d", k));
      finish_rsp($sformatf("vec%0d", k));
    end

    // Random vectors
    for (int k = 0; k < 6; k++) begin
      v = model(2'($urandom_range(0, 3)), $urandom, $urandom);
      send(v);
      wait_rsp($sformatf("rnd%0d", k));
      finish_rsp($sformatf("rnd%0d", k));
    end

    // Backpressure: response held while a second request waits
    send(model(2'b11, 32'h0000_00AA, 32'h0000_0055));
    wait_rsp("bp_first");
    req_op = 2'b00; req_a = 32'h0000_0010; req_b = 32'h0000_0020; req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", k), W'(rsp_valid), W'(1));
      check($sformatf("bp_hold%0d_result", k), rsp_result, 32'h0000_00FF);
      check($sformatf("bp_hold%0d_carry", k), W'(rsp_carry), W'(0));
      check($sformatf("bp_hold%0d_req_ready", k), W'(req_ready), W'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_release_valid", W'(rsp_valid), W'(0));
    check("bp_release_req_ready", W'(req_ready), W'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_second_accepted", W'(req_ready), W'(0));
    sb.push_back('{2'b00, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0, 1'b0, 4});
    wait_rsp("bp_second");
    finish_rsp("bp_second");

    // Reset during the P2 pass of a SUB
    send(vecs[1]);
    @(posedge clk); #1;
    check("abort_in_p2_alu_b", W'(alu_b), W'(8'h01));
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    check("abort_rsp_valid", W'(rsp_valid), W'(0));
    check("abort_rsp_result", rsp_result, '0);
    check("abort_alu_a", W'(alu_a), W'(0));
    check("abort_alu_b", W'(alu_b), W'(0));
    check("abort_req_ready", W'(req_ready), W'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_after", W'(req_ready), W'(1));
    saw_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      saw_valid |= rsp_valid;
    end
    check("abort_no_response", W'(saw_valid), W'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
